// File: rtl/pwr_cntr_arbiter.sv
// pwr_cntr_arbiter
// Synthesizable bank of power accumulators. Each counter sums the weights
// of the 0->1 transition events reported for its index. Several requesters
// (one gate-group monitor per macro) share the bank through a round-robin
// arbiter, so at most one accumulator is updated per cycle. The block also
// provides a sequenced clear and a registered read port.
//
// Ports
//   clk           rising-edge clock for all logic
//   reset         synchronous, active-high reset (starts a full clear)
//   req_valid     per-requester update request
//   req_idx       requester i's counter index at [i*IDX_W +: IDX_W]
//   req_weight    requester i's event weight at [i*WT_W +: WT_W]
//   req_ready     one-hot grant, combinational from req_valid and state
//   clr_start     one-cycle pulse requesting a clear of every accumulator
//   rd_valid      read request
//   rd_idx        counter to read
//   rd_ready      read accepted this cycle
//   rd_data       registered read value, held between reads
//   rd_data_valid one-cycle pulse marking a fresh rd_data
//   busy          clear sequence in progress
//   sat_flag      sticky: some accumulator has saturated since the last clear

module pwr_cntr_arbiter #(
   parameter int N_REQ  = 4,
   parameter int N_CNTR = 16,
   parameter int IDX_W  = 4,
   parameter int WT_W   = 8,
   parameter int ACC_W  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*IDX_W-1:0] req_idx,
   input  logic [N_REQ*WT_W-1:0]  req_weight,
   output logic [N_REQ-1:0]       req_ready,
   input  logic                   clr_start,
   input  logic                   rd_valid,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic                   rd_ready,
   output logic [ACC_W-1:0]       rd_data,
   output logic                   rd_data_valid,
   output logic                   busy,
   output logic                   sat_flag
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (N_CNTR > 1) ? $clog2(N_CNTR) : 1;
   // One extra bit above the wider operand catches the carry out of the add.
   localparam int SUM_W = ((ACC_W > WT_W) ? ACC_W : WT_W) + 1;
   localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

   typedef enum logic {CLEAR, RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   clr_cnt;
   logic [PTR_W-1:0]   rr_ptr;
   logic [ACC_W-1:0]   acc [N_CNTR];

   logic               grant_any;
   logic [PTR_W-1:0]   grant_id;
   logic [PTR_W:0]     scan_pos;
   logic [PTR_W:0]     ptr_next;
   logic [IDX_W-1:0]   sel_idx;
   logic [WT_W-1:0]    sel_wt;
   logic [CNT_W-1:0]   upd_cidx;
   logic               upd_ok;
   logic [SUM_W-1:0]   upd_sum;
   logic               upd_ovf;
   logic [CNT_W-1:0]   rd_cidx;
   logic               rd_ok;

   assign busy     = (state == CLEAR);
   assign rd_ready = (state == RUN);

   // Round-robin search: start at rr_ptr and take the first active request,
   // wrapping at N_REQ. Nothing is granted while the bank is being cleared.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      scan_pos  = '0;
      if (state == RUN) begin
         for (int k = 0; k < N_REQ; k++) begin
            scan_pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_pos >= (PTR_W+1)'(N_REQ)) begin
               scan_pos = scan_pos - (PTR_W+1)'(N_REQ);
            end
            if (!grant_any && req_valid[scan_pos[PTR_W-1:0]]) begin
               grant_any = 1'b1;
               grant_id  = scan_pos[PTR_W-1:0];
            end
         end
      end
   end

   // One-hot grant vector driven from the search result.
   always_comb begin
      req_ready = '0;
      if (grant_any) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   // Pointer moves to the requester just after the winner so it becomes the
   // lowest priority next cycle.
   always_comb begin
      ptr_next = {1'b0, grant_id} + (PTR_W+1)'(1);
      if (ptr_next >= (PTR_W+1)'(N_REQ)) begin
         ptr_next = '0;
      end
   end

   // Operands of the granted update. An index outside the bank is still
   // accepted by the arbiter but must leave every accumulator untouched.
   always_comb begin
      sel_idx  = req_idx[grant_id*IDX_W +: IDX_W];
      sel_wt   = req_weight[grant_id*WT_W +: WT_W];
      upd_cidx = sel_idx[CNT_W-1:0];
      upd_ok   = ({1'b0, sel_idx} < (IDX_W+1)'(N_CNTR));
      upd_sum  = SUM_W'(acc[upd_cidx]) + SUM_W'(sel_wt);
      upd_ovf  = (upd_sum > ACC_MAX);
      rd_cidx  = rd_idx[CNT_W-1:0];
      rd_ok    = ({1'b0, rd_idx} < (IDX_W+1)'(N_CNTR));
   end

   // Main FSM. CLEAR walks clr_cnt across the bank zeroing one accumulator
   // per cycle; RUN applies the granted update and serves reads. A read of
   // the index being updated sees the pre-update value because both use the
   // accumulator contents from before this edge. A clear requested together
   // with an update lets the update land first; the sweep then erases it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= CLEAR;
         clr_cnt       <= '0;
         rr_ptr        <= '0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
         sat_flag      <= 1'b0;
      end else begin
         rd_data_valid <= 1'b0;
         case (state)
            CLEAR: begin
               acc[clr_cnt] <= '0;
               if (clr_cnt == CNT_W'(N_CNTR-1)) begin
                  state <= RUN;
               end else begin
                  clr_cnt <= clr_cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (grant_any) begin
                  rr_ptr <= ptr_next[PTR_W-1:0];
                  if (upd_ok) begin
                     if (upd_ovf) begin
                        acc[upd_cidx] <= '1;
                        sat_flag      <= 1'b1;
                     end else begin
                        acc[upd_cidx] <= upd_sum[ACC_W-1:0];
                     end
                  end
               end
               if (rd_valid) begin
                  rd_data_valid <= 1'b1;
                  rd_data       <= rd_ok ? acc[rd_cidx] : '0;
               end
               if (clr_start) begin
                  state    <= CLEAR;
                  clr_cnt  <= '0;
                  sat_flag <= 1'b0;
               end
            end
            default: begin
               state <= CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwr_cntr_arbiter.sv
// tb_pwr_cntr_arbiter
// Directed-vector bench for pwr_cntr_arbiter. The DUT is built with IDX_W=5
// so out-of-range indices (20) can be driven, and with ACC_W=8 so saturation
// can be reached in a handful of updates. Inputs change on the falling edge
// and outputs are sampled there (or #1 later for the combinational grant).

module tb_pwr_cntr_arbiter;

   localparam int N_REQ  = 4;
   localparam int N_CNTR = 16;
   localparam int IDX_W  = 5;
   localparam int WT_W   = 8;
   localparam int ACC_W  = 8;

   logic                   clk;
   logic                   reset;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*IDX_W-1:0] req_idx;
   logic [N_REQ*WT_W-1:0]  req_weight;
   logic [N_REQ-1:0]       req_ready;
   logic                   clr_start;
   logic                   rd_valid;
   logic [IDX_W-1:0]       rd_idx;
   logic                   rd_ready;
   logic [ACC_W-1:0]       rd_data;
   logic                   rd_data_valid;
   logic                   busy;
   logic                   sat_flag;

   int checkCount;
   int errorCount;

   pwr_cntr_arbiter #(
      .N_REQ (N_REQ),
      .N_CNTR(N_CNTR),
      .IDX_W (IDX_W),
      .WT_W  (WT_W),
      .ACC_W (ACC_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_idx      (req_idx),
      .req_weight   (req_weight),
      .req_ready    (req_ready),
      .clr_start    (clr_start),
      .rd_valid     (rd_valid),
      .rd_idx       (rd_idx),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .rd_data_valid(rd_data_valid),
      .busy         (busy),
      .sat_flag     (sat_flag)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the requester bus in one go.
   task automatic applyStimulus(input logic [N_REQ-1:0] v,
                                input logic [N_REQ*IDX_W-1:0] idx,
                                input logic [N_REQ*WT_W-1:0] wt);
      req_valid  = v;
      req_idx    = idx;
      req_weight = wt;
   endtask

   // One requester alone: expect an immediate grant, transfer on the next edge.
   task automatic sendUpdate(input int r, input logic [IDX_W-1:0] idx,
                             input logic [WT_W-1:0] wt, input string tag);
      logic [N_REQ*IDX_W-1:0] idxBus;
      logic [N_REQ*WT_W-1:0]  wtBus;
      logic [N_REQ-1:0]       oneHot;
      idxBus = '0;
      wtBus  = '0;
      idxBus[r*IDX_W +: IDX_W] = idx;
      wtBus[r*WT_W +: WT_W]    = wt;
      oneHot = N_REQ'(1) << r;
      applyStimulus(oneHot, idxBus, wtBus);
      #1;
      checkOutput(tag, 32'(req_ready), 32'(oneHot));
      @(negedge clk);
      applyStimulus('0, '0, '0);
   endtask

   // Single read: request on a falling edge, result visible one cycle later.
   task automatic readCounter(input logic [IDX_W-1:0] idx, output logic [ACC_W-1:0] val,
                              output logic vld);
      rd_valid = 1'b1;
      rd_idx   = idx;
      @(posedge clk);
      @(negedge clk);
      rd_valid = 1'b0;
      val      = rd_data;
      vld      = rd_data_valid;
   endtask

   // Count falling edges that see busy high; optionally fires a clr_start
   // inside the sweep, which the DUT must ignore.
   task automatic countBusy(input logic pulseInside, output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         clr_start = pulseInside && (n == 5);
         @(negedge clk);
      end
      clr_start = 1'b0;
   endtask

   logic [ACC_W-1:0] val;
   logic             vld;
   int               n;
   logic [7:0]       expSweep [6];

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset      = 1'b1;
      clr_start  = 1'b0;
      rd_valid   = 1'b0;
      rd_idx     = '0;
      applyStimulus(4'hF, '0, '0);
      repeat (3) @(negedge clk);

      // Reset state: clearing, nothing granted, outputs zero.
      checkOutput("rst_busy", 32'(busy), 32'd1);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rd_ready", 32'(rd_ready), 32'd0);
      checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
      checkOutput("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
      checkOutput("rst_sat_flag", 32'(sat_flag), 32'd0);
      applyStimulus('0, '0, '0);

      // Release reset: exactly 16 busy cycles, then reads of every counter are 0.
      reset = 1'b0;
      countBusy(1'b0, n);
      checkOutput("init_clear_cycles", 32'(n), 32'd16);
      checkOutput("run_rd_ready", 32'(rd_ready), 32'd1);
      for (int i = 0; i < N_CNTR; i++) begin
         readCounter(IDX_W'(i), val, vld);
         checkOutput($sformatf("init_read_%0d", i), 32'(val), 32'd0);
      end
      checkOutput("init_read_valid", 32'(vld), 32'd1);

      // Requester 2 alone, idx 5, weight 3, four transfers -> 12.
      for (int k = 0; k < 4; k++) begin
         sendUpdate(2, 5'd5, 8'd3, $sformatf("req2_grant_%0d", k));
      end
      readCounter(5'd5, val, vld);
      checkOutput("req2_acc5", 32'(val), 32'd12);
      checkOutput("req2_rd_valid", 32'(vld), 32'd1);
      @(negedge clk);
      checkOutput("rd_valid_pulse_end", 32'(rd_data_valid), 32'd0);
      checkOutput("rd_data_hold", 32'(rd_data), 32'd12);

      // Requester 3 with idx 20: accepted, discarded (acc[4] must not alias),
      // and rr_ptr wraps from 3 back to 0.
      sendUpdate(3, 5'd20, 8'd9, "oob_grant");
      readCounter(5'd4, val, vld);
      checkOutput("oob_no_alias_acc4", 32'(val), 32'd0);

      // All four requesters continuously valid: grants rotate 0,1,2,3,0,1,2,3.
      applyStimulus(4'hF, {5'd3, 5'd2, 5'd1, 5'd0}, {8'd1, 8'd1, 8'd1, 8'd1});
      for (int k = 0; k < 8; k++) begin
         #1;
         checkOutput($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
         @(negedge clk);
      end
      applyStimulus('0, '0, '0);

      // Back-to-back reads every cycle: idx 0..5 -> 2,2,2,2,0,12.
      expSweep = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd12};
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) begin
            checkOutput($sformatf("b2b_read_%0d", i - 1), 32'(rd_data), 32'(expSweep[i-1]));
            checkOutput($sformatf("b2b_valid_%0d", i - 1), 32'(rd_data_valid), 32'd1);
         end
         rd_valid = (i < 6);
         rd_idx   = IDX_W'(i);
         @(negedge clk);
      end

      // Exact fit at the top of the range does not saturate.
      sendUpdate(0, 5'd8, 8'hFF, "fit_grant");
      readCounter(5'd8, val, vld);
      checkOutput("fit_acc8", 32'(val), 32'hFF);
      checkOutput("fit_no_sat", 32'(sat_flag), 32'd0);

      // acc[7] to 0xF0, then +0x20 saturates to all-ones and sets sat_flag.
      sendUpdate(0, 5'd7, 8'h78, "sat_pre_0");
      sendUpdate(0, 5'd7, 8'h78, "sat_pre_1");
      readCounter(5'd7, val, vld);
      checkOutput("sat_pre_acc7", 32'(val), 32'hF0);
      sendUpdate(0, 5'd7, 8'h20, "sat_grant");
      checkOutput("sat_flag_set", 32'(sat_flag), 32'd1);
      readCounter(5'd7, val, vld);
      checkOutput("sat_acc7", 32'(val), 32'hFF);
      sendUpdate(1, 5'd7, 8'h00, "zero_wt_grant");
      readCounter(5'd7, val, vld);
      checkOutput("zero_wt_acc7", 32'(val), 32'hFF);

      // Clear: 16 busy cycles (a clr_start inside is ignored), sat_flag and
      // counters back to zero.
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      checkOutput("clr_req_ready", 32'(req_ready), 32'd0);
      countBusy(1'b1, n);
      checkOutput("clr_cycles", 32'(n), 32'd16);
      checkOutput("clr_sat_flag", 32'(sat_flag), 32'd0);
      readCounter(5'd7, val, vld);
      checkOutput("clr_acc7", 32'(val), 32'd0);
      readCounter(5'd5, val, vld);
      checkOutput("clr_acc5", 32'(val), 32'd0);

      // Same-cycle read and update of idx 3: old value 10, then 15.
      sendUpdate(1, 5'd3, 8'd10, "rw_pre_grant");
      rd_valid = 1'b1;
      rd_idx   = 5'd3;
      sendUpdate(1, 5'd3, 8'd5, "rw_grant");
      rd_valid = 1'b0;
      checkOutput("rw_old_value", 32'(rd_data), 32'd10);
      readCounter(5'd3, val, vld);
      checkOutput("rw_new_value", 32'(val), 32'd15);

      // Out-of-range read returns 0 even when the aliased counter is non-zero.
      sendUpdate(0, 5'd4, 8'd7, "alias_grant");
      readCounter(5'd20, val, vld);
      checkOutput("oob_read", 32'(val), 32'd0);
      checkOutput("oob_read_valid", 32'(vld), 32'd1);
      readCounter(5'd4, val, vld);
      checkOutput("alias_acc4", 32'(val), 32'd7);

      // Reset in the middle of a clear restarts a full 16-cycle sweep.
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midclr_rst_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      countBusy(1'b0, n);
      checkOutput("midclr_cycles", 32'(n), 32'd16);
      readCounter(5'd3, val, vld);
      checkOutput("midclr_acc3", 32'(val), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
